pcileech_tlps128_cfgspace_ctrl: RTL
===================================

PCILEECH_TLPS128_CFGSPACE_CTRL -- requirements
Module: pcileech_tlps128_cfgspace_ctrl

Interface
REQ-001 Parameter RD_TIMEOUT, default 16, cycles to wait for read data before the timeout response.
REQ-002 Single clock; reset is asynchronous, active-low; ports clk, reset_n.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset_n  in  1  async active-low reset.
REQ-005 tlp_rx_data  in  128  request TLP; DW0 [31:0], DW1 [63:32], DW2 [95:64], write payload [127:96].
REQ-006 tlp_rx_valid / tlp_rx_ready  in/out  1  request handshake, transfer when both high.
REQ-007 completer_id  in  16  bus/dev/fn placed in completions.
REQ-008 cfg_ext_read_received, cfg_ext_write_received  out  1  one-cycle strobes to config shadow.
REQ-009 cfg_ext_register_number  out  10; cfg_ext_function_number  out  4; cfg_ext_write_data  out  32; cfg_ext_write_byte_enable  out  4.
REQ-010 cfg_ext_read_data  in  32; cfg_ext_read_data_valid  in  1  shadow read return.
REQ-011 tlp_tx_data  out  128; tlp_tx_valid  out  1; tlp_tx_ready  in  1  completion TLP, DW0-DW3 same packing as rx.

Function
REQ-012 FSM states IDLE, DECODE, ISSUE, WAIT_RD, WAIT_WR, SEND; tlp_rx_ready high only in IDLE.
REQ-013 IDLE: on rx handshake capture DW0-DW3 into registers, go DECODE.
REQ-014 DECODE: CfgRd0 = fmt 000 type 00100; CfgWr0 = fmt 010 type 00100; Length must equal 1; anything else -> Cpl status UR (001), go SEND.
REQ-015 ISSUE: drive register_number = DW2[11:2], function_number = DW2[19:16] low 4 bits, byte_enable = DW1[3:0], write_data = payload; pulse exactly one strobe one cycle; read -> WAIT_RD, write -> WAIT_WR.
REQ-016 WAIT_RD: latch cfg_ext_read_data on first read_data_valid; if none within RD_TIMEOUT cycles, data = FFFFFFFFh, status SC; go SEND.
REQ-017 WAIT_WR: fixed 3-cycle hold before SEND (shadow write completion spacing); no new strobe issued meanwhile.
REQ-018 Completion header: DW0 fmt 010 type 01010 Length 1 for CplD, fmt 000 type 01010 Length 0 for Cpl; TC/Attr copied from request; DW1 = completer_id, status, BCM 0, ByteCount 4; DW2 = requester_id, tag from request DW1, lower address = DW2[6:0].
REQ-019 Write and UR completions are Cpl (no data); successful/timeout reads are CplD with data in [127:96].
REQ-020 SEND: tlp_tx_valid held high, tlp_tx_data stable until tlp_tx_ready; then IDLE the following cycle.
REQ-021 read_data_valid arriving outside WAIT_RD is ignored; strobes never overlap; at most one request in flight.
REQ-022 Latency: CfgWr0 rx handshake to tx_valid = 6 cycles; CfgRd0 = 4 cycles plus shadow read latency.

Reset
REQ-023 On reset_n low: FSM IDLE, all strobes 0, tlp_tx_valid 0, tlp_rx_ready 1 after release, all cfg_ext_* data outputs and tlp_tx_data 0, timeout counter 0.
REQ-024 Reset mid-transaction abandons it; no completion is emitted for the aborted request.

Configuration
REQ-025 Macro CFGSPACE_CTRL_UR_COUNT_EN: defined -> extra output ur_count (16 bits, saturating at FFFFh, reset 0) increments once per UR completion sent; undefined -> port and counter absent, behaviour otherwise identical.

Structure
REQ-026 Package pcileech_cfgspace_pkg holds FSM state enum, fmt/type constants (CFGRD0, CFGWR0, CPL, CPLD) and completion status constants (SC, UR).
REQ-027 Sub-module pcileech_tlps128_cpl_builder assembles the 128-bit completion from captured fields, status and data.

Verification
REQ-028 CfgRd0 reg 001h, tag 05h, shadow returns 00100007h 2 cycles later -> one read strobe, CplD status SC, tag 05, ByteCount 4, data 00100007h.
REQ-029 CfgWr0 reg 001h, BE 0011b, data 00000406h -> one write strobe with those values, Cpl status SC after 6 cycles, no data.
REQ-030 CfgRd0 with shadow silent -> after 16 cycles CplD data FFFFFFFFh, status SC.
REQ-031 MemRd32 or CfgRd0 with Length 2 -> no strobe, Cpl status UR; with macro ur_count 0 -> 1.
REQ-032 tlp_tx_ready low for 10 cycles during SEND -> tx_data stable, rx_ready low throughout; reset_n pulsed in WAIT_RD -> no completion, outputs at reset values.

Source files
------------

// File: rtl/pcileech_cfgspace_pkg.sv
// Shared types and constants for the 128-bit TLP configuration-space controller.
package pcileech_cfgspace_pkg;

  typedef enum logic [2:0] {
    IDLE, DECODE, ISSUE, WAIT_RD, WAIT_WR, SEND
  } state_e;

  // {fmt[2:0], type[4:0]} as found in DW0[31:24]
  localparam logic [7:0] CFGRD0 = 8'b000_00100;
  localparam logic [7:0] CFGWR0 = 8'b010_00100;
  localparam logic [7:0] CPL    = 8'b000_01010;
  localparam logic [7:0] CPLD   = 8'b010_01010;

  localparam logic [2:0] SC = 3'b000;
  localparam logic [2:0] UR = 3'b001;

  localparam int WR_HOLD = 3;

endpackage

// File: rtl/pcileech_tlps128_cpl_builder.sv
// Assembles a 128-bit completion TLP from the captured request, status and read data.
module pcileech_tlps128_cpl_builder
  import pcileech_cfgspace_pkg::*;
(
  input  logic [31:0]  req_dw0_i,
  input  logic [31:0]  req_dw1_i,
  input  logic [31:0]  req_dw2_i,
  input  logic [15:0]  completer_id_i,
  input  logic [2:0]   status_i,
  input  logic         has_data_i,
  input  logic [31:0]  data_i,
  output logic [127:0] cpl_o
);

  logic [7:0] fmt_type;
  assign fmt_type = has_data_i ? CPLD : CPL;

  // TC and Attr[1:0] follow the request; Length is 1 DW only for CplD
  assign cpl_o[31:0]   = {fmt_type, 1'b0, req_dw0_i[22:20], 6'b0, req_dw0_i[13:12],
                          2'b0, {9'b0, has_data_i}};
  assign cpl_o[63:32]  = {completer_id_i, status_i, 1'b0, 12'd4};
  assign cpl_o[95:64]  = {req_dw1_i[31:16], req_dw1_i[15:8], 1'b0, req_dw2_i[6:0]};
  assign cpl_o[127:96] = has_data_i ? data_i : 32'h0;

endmodule

// File: rtl/pcileech_tlps128_cfgspace_ctrl.sv
// Type-0 config read/write TLP handler bridging to the config shadow.
// Optional CFGSPACE_CTRL_UR_COUNT_EN adds a saturating UR completion counter output.
module pcileech_tlps128_cfgspace_ctrl
  import pcileech_cfgspace_pkg::*;
#(
  parameter int RD_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] tlp_rx_data,
  input  logic         tlp_rx_valid,
  output logic         tlp_rx_ready,
  input  logic [15:0]  completer_id,
  output logic         cfg_ext_read_received,
  output logic         cfg_ext_write_received,
  output logic [9:0]   cfg_ext_register_number,
  output logic [3:0]   cfg_ext_function_number,
  output logic [31:0]  cfg_ext_write_data,
  output logic [3:0]   cfg_ext_write_byte_enable,
  input  logic [31:0]  cfg_ext_read_data,
  input  logic         cfg_ext_read_data_valid,
  output logic [127:0] tlp_tx_data,
  output logic         tlp_tx_valid,
  input  logic         tlp_tx_ready
`ifdef CFGSPACE_CTRL_UR_COUNT_EN
  ,
  output logic [15:0]  ur_count
`endif
);

  localparam int CW = $clog2(RD_TIMEOUT + WR_HOLD + 1);

  state_e           state_q, state_d;
  logic [3:0][31:0] req_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       status_q;
  logic             has_data_q;
  logic [31:0]      data_q;
  logic             rd_stb_q, wr_stb_q;
  logic [9:0]       reg_q;
  logic [3:0]       fn_q, be_q;
  logic [31:0]      wdata_q;
  logic [127:0]     cpl;

  logic rx_hs, is_rd, is_wr, rd_timeout, wr_done, in_wait;
  assign rx_hs      = tlp_rx_valid && tlp_rx_ready;
  assign is_rd      = (req_q[0][31:24] == CFGRD0) && (req_q[0][9:0] == 10'd1);
  assign is_wr      = (req_q[0][31:24] == CFGWR0) && (req_q[0][9:0] == 10'd1);
  assign rd_timeout = cnt_q == CW'(RD_TIMEOUT - 1);
  assign wr_done    = cnt_q == CW'(WR_HOLD - 1);
  assign in_wait    = (state_q == WAIT_RD) || (state_q == WAIT_WR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_hs) state_d = DECODE;
      DECODE:  state_d = (is_rd || is_wr) ? ISSUE : SEND;
      ISSUE:   state_d = is_rd ? WAIT_RD : WAIT_WR;
      WAIT_RD: if (cfg_ext_read_data_valid || rd_timeout) state_d = SEND;
      WAIT_WR: if (wr_done) state_d = SEND;
      SEND:    if (tlp_tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tlp_rx_ready = (state_q == IDLE);
    tlp_tx_valid = (state_q == SEND);
  end

  // Shadow-side outputs are registered: the strobe shows up the cycle after ISSUE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0; cnt_q <= '0; status_q <= SC; has_data_q <= 1'b0; data_q <= '0;
      rd_stb_q <= 1'b0; wr_stb_q <= 1'b0;
      reg_q <= '0; fn_q <= '0; be_q <= '0; wdata_q <= '0;
    end else begin
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      cnt_q    <= (in_wait && state_d == state_q) ? cnt_q + 1'b1 : '0;
      unique case (state_q)
        IDLE:   if (rx_hs) req_q <= tlp_rx_data;
        DECODE: begin
          status_q   <= (is_rd || is_wr) ? SC : UR;
          has_data_q <= 1'b0;
          data_q     <= '0;
        end
        ISSUE: begin
          reg_q    <= req_q[2][11:2];
          fn_q     <= req_q[2][19:16];
          be_q     <= req_q[1][3:0];
          wdata_q  <= req_q[3];
          rd_stb_q <= is_rd;
          wr_stb_q <= is_wr;
        end
        WAIT_RD: begin
          if (cfg_ext_read_data_valid) begin
            data_q     <= cfg_ext_read_data;
            has_data_q <= 1'b1;
          end else if (rd_timeout) begin
            data_q     <= 32'hFFFF_FFFF;
            has_data_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pcileech_tlps128_cpl_builder u_cpl (
    .req_dw0_i      (req_q[0]),
    .req_dw1_i      (req_q[1]),
    .req_dw2_i      (req_q[2]),
    .completer_id_i (completer_id),
    .status_i       (status_q),
    .has_data_i     (has_data_q),
    .data_i         (data_q),
    .cpl_o          (cpl)
  );

  assign tlp_tx_data               = (state_q == SEND) ? cpl : '0;
  assign cfg_ext_read_received     = rd_stb_q;
  assign cfg_ext_write_received    = wr_stb_q;
  assign cfg_ext_register_number   = reg_q;
  assign cfg_ext_function_number   = fn_q;
  assign cfg_ext_write_data        = wdata_q;
  assign cfg_ext_write_byte_enable = be_q;

`ifdef CFGSPACE_CTRL_UR_COUNT_EN
  logic [15:0] ur_cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ur_cnt_q <= '0;
    else if (state_q == SEND && tlp_tx_ready && status_q == UR && ur_cnt_q != 16'hFFFF)
      ur_cnt_q <= ur_cnt_q + 16'd1;
  end
  assign ur_count = ur_cnt_q;
`endif

endmodule
